// File: rtl/alu_operand_driver_pkg.sv
// Shared types and constants for the ALU operand driver.
package alu_operand_driver_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_EDIT_A = 3'd0,
        ST_EDIT_B = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    // Bits needed to hold SETTLE_CYCLES-1, never less than one.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/alu_operand_driver_if.sv
// User buttons, ALU connection and result/display bus of the operand driver.
interface alu_operand_driver_if #(
    parameter int WIDTH = 4
);
    logic             inc;
    logic             next;
    logic             ack;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [2:0]       state_o;
    logic [WIDTH-1:0] result;
    logic             res_valid;

    modport master (
        output inc, next, ack, op_sel, alu_res,
        input  alu_a, alu_b, alu_op, state_o, result, res_valid
    );

    modport slave (
        input  inc, next, ack, op_sel, alu_res,
        output alu_a, alu_b, alu_op, state_o, result, res_valid
    );
endinterface

// File: rtl/alu_operand_driver_settle_counter.sv
// Loadable down-counter timing how long operands settle before sampling.
module alu_operand_driver_settle_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] count_q;

    // Load takes priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/alu_operand_driver.sv
// Operand entry, opcode issue and result capture for a combinational ALU.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  EDIT_A    | inc bumps operand A, next moves to EDIT_B
//  EDIT_B    | inc bumps operand B, next starts a compute
//  ISSUE     | latch opcode, load settle timer (one cycle)
//  SETTLE    | hold operands until timer reaches zero, then capture
//  DONE      | result valid, wait for ack to return to EDIT_A
//  5..7      | illegal, recover to EDIT_A with outputs untouched
module alu_operand_driver
    import alu_operand_driver_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_driver_if.slave  bus
);
    localparam int CNT_W = cnt_width(SETTLE_CYCLES);

    state_t state_q;
    state_t state_d;

    logic inc_a;
    logic inc_b;
    logic load_op;
    logic load_cnt;
    logic dec_cnt;
    logic capture;
    logic clear_valid;
    logic cnt_zero;

    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [1:0]       alu_op_q;
    logic [WIDTH-1:0] result_q;
    logic             res_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EDIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EDIT_A: if (bus.next) state_d = ST_EDIT_B;
            ST_EDIT_B: if (bus.next) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_zero) state_d = ST_DONE;
            ST_DONE:   if (bus.ack)  state_d = ST_EDIT_A;
            default:   state_d = ST_EDIT_A;
        endcase
    end

    // Per-state datapath strobes; illegal states assert none.
    always_comb begin
        inc_a       = 1'b0;
        inc_b       = 1'b0;
        load_op     = 1'b0;
        load_cnt    = 1'b0;
        dec_cnt     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state_q)
            ST_EDIT_A: inc_a = bus.inc;
            ST_EDIT_B: inc_b = bus.inc;
            ST_ISSUE: begin
                load_op  = 1'b1;
                load_cnt = 1'b1;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    capture = 1'b1;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            ST_DONE:   clear_valid = bus.ack;
            default: ;
        endcase
    end

    // Operand, opcode and result registers; operands survive an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (inc_a)   alu_a_q  <= alu_a_q + 1'b1;
            if (inc_b)   alu_b_q  <= alu_b_q + 1'b1;
            if (load_op) alu_op_q <= bus.op_sel;
            if (capture) begin
                result_q    <= bus.alu_res;
                res_valid_q <= 1'b1;
            end else if (clear_valid) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    alu_operand_driver_settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_cnt),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (dec_cnt),
        .zero     (cnt_zero)
    );

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.state_o   = state_q;
    assign bus.result    = result_q;
    assign bus.res_valid = res_valid_q;
endmodule

// File: doc/alu_operand_driver.md
Name: alu_operand_driver

Overview:
Sequential front end that drives the 4-bit ALU operand and opcode inputs and captures its result. The user builds operands A and B with single-cycle button pulses. On a compute command the block presents A, B and the opcode to the combinational ALU and waits a fixed settle time. It then latches the ALU output into a result register with a valid flag for the display logic.

Parameters:
WIDTH, 4, operand/result width in bits
SETTLE_CYCLES, 2, cycles operands are held stable before the result is sampled (min 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
inc  input  1  single-cycle pulse: increment the operand being edited
next  input  1  single-cycle pulse: advance the edit target A -> B -> compute
op_sel  input  2  opcode to issue; sampled on entry to ISSUE
alu_res  input  WIDTH  result from the ALU (e.g. bitwise OR of alu_a, alu_b)
alu_a  output  WIDTH  operand A to the ALU
alu_b  output  WIDTH  operand B to the ALU
alu_op  output  2  opcode to the ALU
state_o  output  3  current FSM state, for debug LEDs
result  output  WIDTH  latched ALU result
res_valid  output  1  high while result holds a fresh, unconsumed value
ack  input  1  consumer pulse: clear res_valid and return to EDIT_A

Behaviour:
- Reset (rst_n low at a clk edge) forces alu_a=0, alu_b=0, alu_op=0, result=0, res_valid=0, state=EDIT_A and settle counter=0.
- Reset mid-operation overrides every other input in that cycle.
- States, in order of encoding: EDIT_A(0), EDIT_B(1), ISSUE(2), SETTLE(3), DONE(4). Encodings 5-7 are illegal and go to EDIT_A on the next cycle with all outputs unchanged.
- EDIT_A:
  - inc pulse: alu_a <= alu_a+1 mod 2^WIDTH; 0xF wraps to 0x0.
  - next pulse: go to EDIT_B.
- EDIT_B: same rules, applied to alu_b. next pulse goes to ISSUE.
- Simultaneous inc and next in an EDIT state: apply the increment to the current operand, then advance. Both take effect on the same edge.
- ISSUE (1 cycle): alu_op <= op_sel, counter <= SETTLE_CYCLES-1, go to SETTLE. inc and next are ignored.
- SETTLE: counter decrements each cycle. When counter==0: result <= alu_res, res_valid <= 1, go to DONE.
- Latency from next in EDIT_B to res_valid high is SETTLE_CYCLES+1 edges. For the default this is the 3rd edge after the one that registered next.
- alu_a, alu_b and alu_op are stable from ISSUE through DONE.
- DONE:
  - Holds result and res_valid.
  - inc and next are ignored.
  - ack: res_valid <= 0, go to EDIT_A. alu_a and alu_b keep their values, so the user edits from the last operands.
- ack outside DONE is ignored. An ack in the same cycle res_valid rises is not possible, because res_valid rises on entry to DONE.
- state_o reflects the registered state.
- No combinational path from inputs to outputs; every output is registered.

Decomposition:
- Shared package/header:
  - state encodings EDIT_A..DONE
  - opcode constants: OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3
  - default WIDTH
- One natural sub-module, settle_counter: a loadable down-counter with a zero flag. The FSM and operand registers stay in the top module.

Test Plan:
1. Reset: hold rst_n low 2 cycles with inc/next toggling -> all outputs 0, state_o=0. Release -> still 0 until the first pulse.
2. OR path: 5 inc, next, 10 inc, next, op_sel=1, ALU model = A|B -> alu_a=0x5, alu_b=0xA, alu_op=1. res_valid rises exactly 3 edges after the second next, with result=0xF.
3. Wrap: 17 inc in EDIT_A -> alu_a=0x1. Simultaneous inc+next with alu_a=0xF -> alu_a=0x0 and state EDIT_B on the same edge.
4. Ignored inputs: inc/next pulses during ISSUE, SETTLE and DONE -> alu_a, alu_b, result unchanged. ack during SETTLE -> ignored, res_valid still rises.
5. ack handshake: in DONE pulse ack -> res_valid=0 next edge, state_o=0, alu_a/alu_b retained. A second compute with op_sel=0 (AND, A=0x5, B=0xA) -> result=0x0.
6. Reset in SETTLE: assert rst_n low for 1 cycle while counter=1 -> no result capture, res_valid=0, all registers 0, state EDIT_A.
